pipe_trace_buffer: RTL and testbench
====================================

Name: pipe_trace_buffer

Overview:
- Synthesizable on-chip trace capture for the core pipeline. Generalises the per-cycle stage printout into hardware recording with parametrised channel count, width and depth.
- Snoops NCH pipeline channels (valid + payload, e.g. IF/ID/EX/WB origaddr) into a circular buffer.
- Stops a programmable number of cycles after a trigger. The frozen history is then read back through an indexed port.
- Sits beside the core as a debug block; has no effect on core timing.

Parameters:
NCH, 4, number of snooped channels
DW, 16, payload bits per channel
DEPTH, 16, buffer entries (power of 2, >=4)
POST, 8, entries recorded after the trigger entry (0 <= POST < DEPTH)
CW, 16, cycle-stamp width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ch_v  in  NCH  per-channel valid
ch_data  in  NCH*DW  channel payloads, channel i at [i*DW +: DW]
arm  in  1  start/restart capture
trig  in  1  trigger event
rd_en  in  1  read request
rd_idx  in  AW  entry index, 0 = oldest (AW = $clog2(DEPTH))
armed  out  1  high in ARMED or POST
done  out  1  high in DONE
count  out  AW+1  valid entries held, saturates at DEPTH
trig_pos  out  AW  index of trigger entry, relative to oldest
rd_valid  out  1  rd_data valid
rd_data  out  EW  entry {trig_flag, stamp[CW], ch_v[NCH], ch_data[NCH*DW]}, EW = 1+CW+NCH+NCH*DW

Behaviour:
- Reset (synchronous, active-high; clk and rst as named above):
  - state=IDLE.
  - wr_ptr, count, stamp, post_cnt, trig_pos, rd_valid and rd_data are all 0.
  - Buffer contents are don't-care.
- States:
  - IDLE: no writes. arm -> ARMED.
  - ARMED: write one entry per recorded cycle. trig -> POST, with that same cycle's entry written with trig_flag=1 and post_cnt=POST. If POST==0, trig -> DONE directly.
  - POST: write one entry per recorded cycle, decrementing post_cnt. The write that brings post_cnt to 0 -> DONE.
  - DONE: frozen, no writes. done=1. arm -> ARMED.
- Arm action:
  - Clears wr_ptr, count and stamp to 0.
  - The arm cycle itself is not recorded; the first entry is the next cycle, with stamp=0.
  - arm in ARMED or POST restarts capture the same way.
- Write action:
  - mem[wr_ptr] <= entry.
  - wr_ptr wraps mod DEPTH.
  - count increments, saturating at DEPTH.
- Stamp: increments every cycle while armed, including cycles that are not recorded; wraps mod 2^CW.
- Priority:
  - arm beats trig.
  - trig in IDLE or DONE is ignored.
  - trig in POST is ignored (single trigger).
- Oldest entry: at wr_ptr if count==DEPTH, else at 0. Physical address = (oldest + rd_idx) mod DEPTH.
- trig_pos:
  - Set at the trigger write to (count_before_write < DEPTH ? count_before_write : DEPTH-1).
  - Held through DONE; cleared on arm.
- Read:
  - rd_en registered; rd_data and rd_valid appear the next cycle, 1-cycle latency.
  - rd_valid is a single-cycle pulse per rd_en.
  - rd_idx >= count returns rd_data=0.
  - Reads are legal in any state. During capture they return the current contents.
  - Read and write to the same entry in one cycle returns the old data.
- rst mid-capture: immediate return to IDLE, with all outputs at their reset values.

Optional Feature:
TRACE_IDLE_SKIP_EN:
- Defined: cycles with ch_v==0 are not written and do not decrement post_cnt. The stamp still advances, so gaps remain visible. The trigger cycle is always written, even when ch_v==0.
- Undefined: every armed cycle is written.

Test Plan (NCH=2, DW=8, DEPTH=8, POST=3, CW=8, macro off unless stated):
1. rst high 2 cycles mid-stream -> armed=0, done=0, count=0, rd_valid=0. Then arm; 3 cycles later trig -> count=7 at DONE, trig_pos=3. Reading idx 3 gives trig_flag=1, stamp=3.
2. arm, then 20 cycles with ch_data[7:0]=cycle number, then trig -> count=8, trig_pos=4. Oldest entry stamp=16. idx 7 stamp=23. Entries beyond the trigger stop after 3.
3. arm and trig in the same cycle from IDLE -> ARMED, trigger ignored. A later trig with POST=0 build -> DONE on the trigger cycle, with the trigger entry at idx count-1.
4. In DONE, rd_en with rd_idx=2, then rd_idx=7 while count=5 -> rd_valid 1 cycle later each. Second read gives rd_data=0. arm in DONE clears count to 0.
5. A second trig during POST and arm during POST -> the extra trig is ignored; arm restarts with stamp=0 and count=0.
6. TRACE_IDLE_SKIP_EN, ch_v alternating 01,00,10,00 -> only non-zero cycles are stored, with stamps 0,2,4,... A trig on a ch_v=00 cycle is still stored.

Source files
------------

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace capture: snoops NCH valid/payload channels into a circular buffer,
// freezes POST entries after a trigger. Optional macro: TRACE_IDLE_SKIP_EN (skip ch_v==0 cycles).
module pipe_trace_buffer #(
  parameter int NCH   = 4,
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int POST  = 8,
  parameter int CW    = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int EW   = 1 + CW + NCH + NCH*DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_v,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic              arm,
  input  logic              trig,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_idx,
  output logic              armed,
  output logic              done,
  output logic [AW:0]       count,
  output logic [AW-1:0]     trig_pos,
  output logic              rd_valid,
  output logic [EW-1:0]     rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   stamp;
  logic [AW-1:0]   post_cnt;
  logic            rec, wr, trig_hit, full;
  logic [AW-1:0]   oldest, rd_addr;

`ifdef TRACE_IDLE_SKIP_EN
  assign rec = |ch_v;
`else
  assign rec = 1'b1;
`endif

  assign full    = (count == (AW+1)'(DEPTH));
  assign oldest  = full ? wr_ptr : '0;
  assign rd_addr = oldest + rd_idx;
  assign armed   = (state == S_ARMED) || (state == S_POST);
  assign done    = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    trig_hit  = 1'b0;
    case (state)
      S_ARMED: begin
        trig_hit = trig;
        wr       = rec | trig;
        if (trig) state_nxt = (POST == 0) ? S_DONE : S_POST;
      end
      S_POST: begin
        wr = rec;
        if (rec && post_cnt == AW'(1)) state_nxt = S_DONE;
      end
      default: ;
    endcase
    // arm restarts capture from any state and wins over a same-cycle trigger
    if (arm) begin
      state_nxt = S_ARMED;
      wr        = 1'b0;
      trig_hit  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      stamp    <= '0;
      post_cnt <= '0;
      trig_pos <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= ({1'b0, rd_idx} < count) ? mem[rd_addr] : '0;
      if (arm) begin
        wr_ptr   <= '0;
        count    <= '0;
        stamp    <= '0;
        post_cnt <= '0;
        trig_pos <= '0;
      end else begin
        if (armed) stamp <= stamp + CW'(1);
        if (wr) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (!full) count <= count + (AW+1)'(1);
          if (trig_hit) begin
            trig_pos <= full ? AW'(DEPTH-1) : count[AW-1:0];
            post_cnt <= AW'(POST);
          end else if (state == S_POST) begin
            post_cnt <= post_cnt - AW'(1);
            // once full, every write drops the oldest entry, so the trigger moves one closer
            if (full) trig_pos <= trig_pos - AW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {trig_hit, stamp, ch_v, ch_data};
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer: queue-based history model checked every cycle,
// plus directed literal checks (second instance built with POST=0).
module tb_pipe_trace_buffer;
  localparam int NCH = 2, DW = 8, DEPTH = 8, POST = 3, CW = 8;
  localparam int AW = 3, EW = 1 + CW + NCH + NCH*DW;

  logic clk = 0, rst = 0, arm = 0, trig = 0, rd_en = 0;
  logic [NCH-1:0] ch_v = '1;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [AW-1:0] rd_idx = '0;

  logic armed, done, rd_valid, armed0, done0, rd_valid0;
  logic [AW:0] count, count0;
  logic [AW-1:0] trig_pos, trig_pos0;
  logic [EW-1:0] rd_data, rd_data0;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pipe_trace_buffer #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .POST(POST), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ch_v(ch_v), .ch_data(ch_data), .arm(arm), .trig(trig),
    .rd_en(rd_en), .rd_idx(rd_idx), .armed(armed), .done(done), .count(count),
    .trig_pos(trig_pos), .rd_valid(rd_valid), .rd_data(rd_data));

  pipe_trace_buffer #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .POST(0), .CW(CW)) dut0 (
    .clk(clk), .rst(rst), .ch_v(ch_v), .ch_data(ch_data), .arm(arm), .trig(trig),
    .rd_en(rd_en), .rd_idx(rd_idx), .armed(armed0), .done(done0), .count(count0),
    .trig_pos(trig_pos0), .rd_valid(rd_valid0), .rd_data(rd_data0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: history queue of what was recorded, oldest first, trimmed to DEPTH.
  logic [EW-1:0] hist[$];
  logic [EW-1:0] m_rdd;
  logic [CW-1:0] m_stamp;
  bit m_cap, m_post, m_done, m_seen, m_rdv, m_ok = 0;
  int m_left, m_tp;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      hist.delete();
      m_cap = 0; m_post = 0; m_done = 0; m_seen = 0;
      m_stamp = 0; m_tp = 0; m_left = 0; m_rdv = 0; m_rdd = '0; m_ok = 1;
    end else begin
      bit is_trig, rec;
      m_rdv = rd_en;
      if (rd_en) m_rdd = (int'(rd_idx) < hist.size()) ? hist[rd_idx] : '0;
      if (arm) begin
        hist.delete();
        m_stamp = 0; m_tp = 0; m_cap = 1; m_post = 0; m_done = 0; m_seen = 0;
      end else if (m_cap) begin
        is_trig = trig && !m_post;
`ifdef TRACE_IDLE_SKIP_EN
        rec = (ch_v != 0) || is_trig;
`else
        rec = 1;
`endif
        if (rec) begin
          hist.push_back({is_trig, m_stamp, ch_v, ch_data});
          if (hist.size() > DEPTH) begin
            hist.delete(0);
            if (m_seen) m_tp--;
          end
          if (is_trig) begin
            m_seen = 1;
            m_tp = hist.size() - 1;
            if (POST == 0) begin m_cap = 0; m_done = 1; end
            else begin m_post = 1; m_left = POST; end
          end else if (m_post) begin
            m_left--;
            if (m_left == 0) begin m_cap = 0; m_post = 0; m_done = 1; end
          end
        end
        m_stamp = m_stamp + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("armed", 32'(armed), 32'(m_cap));
      chk("done", 32'(done), 32'(m_done));
      chk("count", 32'(count), 32'(hist.size()));
      chk("trig_pos", 32'(trig_pos), 32'(m_tp));
      chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
      chk("rd_data", 32'(rd_data), 32'(m_rdd));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic step(input int k, input logic tg);
    ch_data = {8'(k) ^ 8'h5a, 8'(k)};
    trig = tg;
    tick();
    trig = 0;
  endtask

  task automatic do_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic do_read(input int idx, output logic v, output logic [EW-1:0] d);
    rd_en = 1; rd_idx = AW'(idx); tick(); rd_en = 0;
    v = rd_valid; d = rd_data;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 30) begin tick(); n++; end
    chk(nm, 32'(done), 32'd1);
  endtask

  logic v;
  logic [EW-1:0] d;

  initial begin
    rst = 1; tick(); rst = 0;
    // 1: reset mid-stream, then short capture
    do_arm();
    for (int k = 0; k < 3; k++) step(k, 0);
    rst = 1; tick(); tick(); rst = 0;
    chk("t1_rst_armed", 32'(armed), 0);
    chk("t1_rst_done", 32'(done), 0);
    chk("t1_rst_count", 32'(count), 0);
    chk("t1_rst_rdv", 32'(rd_valid), 0);
    do_arm();
    for (int k = 0; k < 4; k++) step(k, k == 3);
    wait_done("t1_done");
    chk("t1_count", 32'(count), 7);
    chk("t1_trig_pos", 32'(trig_pos), 3);
    do_read(3, v, d);
    chk("t1_rd_valid", 32'(v), 1);
    chk("t1_trig_flag", 32'(d[26]), 1);
    chk("t1_stamp", 32'(d[25:18]), 3);

    // 2: wraparound
    do_arm();
    for (int k = 0; k <= 20; k++) step(k, k == 20);
    for (int k = 21; k < 40 && !done; k++) step(k, 0);
    wait_done("t2_done");
    chk("t2_count", 32'(count), 8);
    chk("t2_trig_pos", 32'(trig_pos), 4);
    do_read(0, v, d);
    chk("t2_oldest_stamp", 32'(d[25:18]), 16);
    do_read(7, v, d);
    chk("t2_idx7_stamp", 32'(d[25:18]), 23);
    do_read(4, v, d);
    chk("t2_idx4_flag", 32'(d[26]), 1);
    chk("t2_idx4_data", 32'(d[7:0]), 20);

    // 3: arm beats trig; POST=0 instance freezes on the trigger cycle
    rst = 1; tick(); rst = 0;
    arm = 1; trig = 1; tick(); arm = 0; trig = 0;
    chk("t3_armed", 32'(armed), 1);
    chk("t3_armed0", 32'(armed0), 1);
    chk("t3_done0_early", 32'(done0), 0);
    step(0, 0); step(1, 0); step(2, 1);
    chk("t3_done0", 32'(done0), 1);
    chk("t3_count0", 32'(count0), 3);
    chk("t3_trig_pos0", 32'(trig_pos0), 2);
    do_read(2, v, d);
    chk("t3_flag0", 32'(rd_data0[26]), 1);
    chk("t3_stamp0", 32'(rd_data0[25:18]), 2);
    wait_done("t3_done");

    // 4: reads in DONE, out-of-range read, arm clears
    do_arm();
    step(0, 0); step(1, 1);
    wait_done("t4_done");
    chk("t4_count", 32'(count), 5);
    chk("t4_trig_pos", 32'(trig_pos), 1);
    do_read(2, v, d);
    chk("t4_rdv_a", 32'(v), 1);
    chk("t4_stamp_a", 32'(d[25:18]), 2);
    do_read(7, v, d);
    chk("t4_rdv_b", 32'(v), 1);
    chk("t4_data_b", 32'(d), 0);
    tick();
    chk("t4_rdv_pulse", 32'(rd_valid), 0);
    do_arm();
    chk("t4_count_arm", 32'(count), 0);

    // 5: second trig in POST ignored, arm in POST restarts
    step(0, 0); step(1, 0); step(2, 1); step(3, 0); step(4, 1);
    chk("t5_still_armed", 32'(armed), 1);
    chk("t5_not_done", 32'(done), 0);
    do_arm();
    chk("t5_count_arm", 32'(count), 0);
    step(0, 0);
    do_read(0, v, d);
    chk("t5_stamp0", 32'(d[25:18]), 0);
    chk("t5_flag0", 32'(d[26]), 0);

`ifdef TRACE_IDLE_SKIP_EN
    // 6: idle skip
    do_arm();
    for (int k = 0; k < 12 && !done; k++) begin
      ch_v = (k % 4 == 0) ? 2'b01 : (k % 4 == 2) ? 2'b10 : 2'b00;
      step(k, k == 3);
    end
    ch_v = 2'b11;
    wait_done("t6_done");
    chk("t6_count", 32'(count), 6);
    chk("t6_trig_pos", 32'(trig_pos), 2);
    do_read(1, v, d);
    chk("t6_stamp1", 32'(d[25:18]), 2);
    do_read(2, v, d);
    chk("t6_trig_flag", 32'(d[26]), 1);
    chk("t6_trig_v", 32'(d[17:16]), 0);
`endif

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
